// File: rtl/priority_demux21.sv
// Registered 1-to-6 priority demultiplexer: one held word, routed by s4..s0 (s4 highest),
// released on sink ready or dropped after TIMEOUT stalled cycles.
module priority_demux21 #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    input  logic             s3,
    input  logic             s4,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y4,
    output logic [WIDTH-1:0] y5,
    output logic [WIDTH-1:0] y6,
    output logic             v1,
    output logic             v2,
    output logic             v3,
    output logic             v4,
    output logic             v5,
    output logic             v6,
    input  logic             rdy1,
    input  logic             rdy2,
    input  logic             rdy3,
    input  logic             rdy4,
    input  logic             rdy5,
    input  logic             rdy6,
    output logic             drop,
    output logic             dbg_state
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t          state;
    logic [WIDTH-1:0] data_q;
    logic [2:0]      dest_q;
    logic [TW-1:0]   timer_q;
    logic [2:0]      dest_enc;
    logic            rdy_sel;
    logic            accept;
    logic            timeout_hit;

    // Handshake: a word moves only when valid and ready are both high at a rising edge;
    // ready never depends on valid, and while FULL it is the selected sink's ready.
    assign din_ready   = (state == EMPTY) || rdy_sel;
    assign accept      = din_valid && din_ready;
    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TLAST);
    assign dbg_state   = (state == FULL);

    always_comb begin
        dest_enc = 3'd1;
        if (s4)      dest_enc = 3'd6;
        else if (s3) dest_enc = 3'd5;
        else if (s2) dest_enc = 3'd4;
        else if (s1) dest_enc = 3'd3;
        else if (s0) dest_enc = 3'd2;
    end

    always_comb begin
        rdy_sel = 1'b0;
        if (state == FULL) begin
            case (dest_q)
                3'd1:    rdy_sel = rdy1;
                3'd2:    rdy_sel = rdy2;
                3'd3:    rdy_sel = rdy3;
                3'd4:    rdy_sel = rdy4;
                3'd5:    rdy_sel = rdy5;
                3'd6:    rdy_sel = rdy6;
                default: rdy_sel = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            data_q  <= '0;
            dest_q  <= 3'd1;
            timer_q <= '0;
            drop    <= 1'b0;
        end else begin
            drop <= 1'b0;
            case (state)
                EMPTY: begin
                    if (accept) begin
                        data_q  <= din;
                        dest_q  <= dest_enc;
                        timer_q <= '0;
                        state   <= FULL;
                    end
                end
                FULL: begin
                    if (rdy_sel) begin
                        timer_q <= '0;
                        if (accept) begin
                            data_q <= din;
                            dest_q <= dest_enc;
                        end else begin
                            state <= EMPTY;
                        end
                    end else if (timeout_hit) begin
                        // Delivery has already been ruled out, so the stall expiry discards the word.
                        timer_q <= '0;
                        drop    <= 1'b1;
                        state   <= EMPTY;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    always_comb begin
        y1 = '0; y2 = '0; y3 = '0; y4 = '0; y5 = '0; y6 = '0;
        v1 = 1'b0; v2 = 1'b0; v3 = 1'b0; v4 = 1'b0; v5 = 1'b0; v6 = 1'b0;
        if (state == FULL) begin
            case (dest_q)
                3'd1:    begin v1 = 1'b1; y1 = data_q; end
                3'd2:    begin v2 = 1'b1; y2 = data_q; end
                3'd3:    begin v3 = 1'b1; y3 = data_q; end
                3'd4:    begin v4 = 1'b1; y4 = data_q; end
                3'd5:    begin v5 = 1'b1; y5 = data_q; end
                3'd6:    begin v6 = 1'b1; y6 = data_q; end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_priority_demux21.sv
// Bench for priority_demux21: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based model of the held word.
module tb_priority_demux21;

    localparam int W  = 8;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [4:0]   sel = '0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic [5:0]   rdy = '0;
    logic         din_ready, drop, dbg_state;
    logic [W-1:0] y1, y2, y3, y4, y5, y6;
    logic         v1, v2, v3, v4, v5, v6;

    wire [5:0]     v_vec = {v6, v5, v4, v3, v2, v1};
    wire [6*W-1:0] y_vec = {y6, y5, y4, y3, y2, y1};

    int n_cmp = 0;
    int n_err = 0;
    int drop_cnt = 0;

    priority_demux21 #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0(sel[0]), .s1(sel[1]), .s2(sel[2]), .s3(sel[3]), .s4(sel[4]),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6),
        .v1(v1), .v2(v2), .v3(v3), .v4(v4), .v5(v5), .v6(v6),
        .rdy1(rdy[0]), .rdy2(rdy[1]), .rdy3(rdy[2]), .rdy4(rdy[3]), .rdy5(rdy[4]), .rdy6(rdy[5]),
        .drop(drop), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- model: held word as a queue {dest, data} ----------------
    logic [W+2:0] exp_q[$];
    int m_age;
    logic m_drop;

    function automatic int prio_dest(input logic [4:0] s);
        for (int i = 4; i >= 0; i--)
            if (s[i]) return i + 2;
        return 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_age  = 0;
            m_drop = 1'b0;
        end else begin
            bit busy, sink_rdy, can_take;
            int d;
            m_drop   = 1'b0;
            busy     = (exp_q.size() != 0);
            sink_rdy = 1'b0;
            if (busy) begin
                d = int'(exp_q[0][W+2:W]);
                sink_rdy = rdy[d-1];
            end
            can_take = !busy || sink_rdy;
            if (busy) begin
                if (sink_rdy) begin
                    void'(exp_q.pop_front());
                end else if (TO != 0 && m_age == TO) begin
                    void'(exp_q.pop_front());
                    m_drop = 1'b1;
                end else begin
                    m_age++;
                end
            end
            if (can_take && din_valid) begin
                exp_q.push_back({3'(prio_dest(sel)), din});
                m_age = 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            logic [5:0]     e_v;
            logic [6*W-1:0] e_y;
            logic           e_rdy;
            int             d;
            e_v = '0; e_y = '0; e_rdy = 1'b1;
            if (exp_q.size() != 0) begin
                d = int'(exp_q[0][W+2:W]);
                e_v[d-1] = 1'b1;
                e_y[W*(d-1) +: W] = exp_q[0][W-1:0];
                e_rdy = rdy[d-1];
            end
            check("model_din_ready", 64'(din_ready), 64'(e_rdy));
            check("model_v", 64'(v_vec), 64'(e_v));
            check("model_y", 64'(y_vec), 64'(e_y));
            check("model_drop", 64'(drop), 64'(m_drop));
            if (drop) drop_cnt++;
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input logic [4:0] s, input logic [W-1:0] d, input logic val, input logic [5:0] r);
        sel = s; din = d; din_valid = val; rdy = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        cyc(5'b0, '0, 1'b0, 6'h3f);
        cyc(5'b0, '0, 1'b0, 6'h3f);
    endtask

    logic [4:0] pat_sel[5] = '{5'b00000, 5'b00001, 5'b00110, 5'b01000, 5'b11111};
    logic [5:0] pat_v[5]   = '{6'b000001, 6'b000010, 6'b001000, 6'b010000, 6'b100000};
    int pat_port[5]        = '{1, 2, 4, 5, 6};

    initial begin
        int held, d0, stall;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_v", 64'(v_vec), 64'h0);
        check("reset_y", 64'(y_vec), 64'h0);
        check("reset_drop", 64'(drop), 64'h0);
        check("reset_state", 64'(dbg_state), 64'h0);
        rst_n = 1'b1;
        #1;
        check("reset_din_ready", 64'(din_ready), 64'h1);
        @(posedge clk);
        #1;

        // priority encode
        for (int i = 0; i < 5; i++) begin
            logic [6*W-1:0] ey;
            cyc(pat_sel[i], 8'hA5, 1'b1, 6'h3f);
            ey = '0;
            ey[W*(pat_port[i]-1) +: W] = 8'hA5;
            check("prio_v", 64'(v_vec), 64'(pat_v[i]));
            check("prio_y", 64'(y_vec), 64'(ey));
        end
        drain();

        // back-to-back to dest 3
        for (int i = 0; i < 10; i++) begin
            cyc(5'b00010, W'(i), 1'b1, 6'b000100);
            check("b2b_y3", 64'(y3), 64'(i));
            check("b2b_v", 64'(v_vec), 64'b000100);
            check("b2b_din_ready", 64'(din_ready), 64'h1);
        end
        drain();

        // backpressure on dest 6
        d0 = drop_cnt;
        cyc(5'b10000, 8'h3C, 1'b1, 6'h00);
        held = 0;
        for (int i = 0; i < 6; i++) begin
            if (v6 && y6 == 8'h3C) held++;
            sel = 5'b00001; din = 8'h99; din_valid = (i < 5);
            rdy = (i == 5) ? 6'b100000 : 6'b011111;
            #1;
            if (i < 5) check("bp_din_ready", 64'(din_ready), 64'h0);
            @(posedge clk);
            #1;
        end
        check("bp_held_cycles", 64'(held), 64'd6);
        check("bp_v_after", 64'(v_vec), 64'h0);
        check("bp_no_drop", 64'(drop_cnt - d0), 64'h0);
        drain();

        // timeout on dest 2
        d0 = drop_cnt;
        cyc(5'b00001, 8'h77, 1'b1, 6'h00);
        held = 0;
        sel = 5'b0; din_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!v2) break;
            held++;
            @(posedge clk);
            #1;
        end
        check("to_held_cycles", 64'(held), 64'd16);
        check("to_drop_high", 64'(drop), 64'h1);
        cyc(5'b00000, 8'h11, 1'b1, 6'h00);
        check("to_drop_low", 64'(drop), 64'h0);
        check("to_drop_count", 64'(drop_cnt - d0), 64'h1);
        check("to_next_v1", 64'(v_vec), 64'b000001);
        check("to_next_y1", 64'(y1), 64'h11);
        drain();

        // select change while FULL
        cyc(5'b00100, 8'h4D, 1'b1, 6'h00);
        for (int i = 0; i < 4; i++) begin
            cyc(5'b10000, W'($urandom), 1'b1, (i % 2 == 0) ? 6'b100000 : 6'b000000);
            check("selchg_v", 64'(v_vec), 64'b001000);
            check("selchg_y4", 64'(y4), 64'h4D);
        end
        cyc(5'b10000, 8'h00, 1'b0, 6'b001000);
        check("selchg_delivered", 64'(v_vec), 64'h0);
        drain();

        // reset mid-hold
        d0 = drop_cnt;
        cyc(5'b01000, 8'h5E, 1'b1, 6'h00);
        check("rst_v5_before", 64'(v_vec), 64'b010000);
        din_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_v_cleared", 64'(v_vec), 64'h0);
        check("rst_y_cleared", 64'(y_vec), 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_din_ready", 64'(din_ready), 64'h1);
        cyc(5'b0, '0, 1'b0, 6'h00);
        check("rst_no_drop", 64'(drop_cnt - d0), 64'h0);

        // random traffic
        stall = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] r;
            if (stall > 0) begin
                r = 6'h00;
                stall--;
            end else begin
                r = 6'($urandom);
                if ($urandom_range(0, 40) == 0) stall = $urandom_range(10, 24);
            end
            cyc(5'($urandom_range(0, 31) >> $urandom_range(0, 4)), W'($urandom),
                ($urandom_range(0, 9) < 7), r);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/priority_demux21.md
# priority_demux21

Registered 1-to-6 priority demultiplexer with valid/ready handshaking. It is the send-side counterpart of the five-select priority mux chain. It accepts one data word per handshake and resolves the destination from select lines s0..s4, with the higher index taking priority. The word is held in a single-entry output stage until the selected sink accepts it, or until a hold timeout expires and the word is dropped.

## Interface
- WIDTH, 8, data width of din and y1..y6
- TIMEOUT, 16, number of FULL cycles without sink acceptance before the held word is dropped; 0 disables the timeout
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- s0,s1,s2,s3,s4  in  1 each  destination selects; s4 has highest priority
- din  in  WIDTH  input data word
- din_valid  in  1  din is offered this cycle
- din_ready  out  1  block accepts din this cycle
- y1..y6  out  WIDTH each  output data; only the selected port carries the held word, all others drive 0
- v1..v6  out  1 each  output valid; at most one asserted
- rdy1..rdy6  in  1 each  sink ready per output
- drop  out  1  one-cycle pulse when a held word is discarded by timeout

## Operation
- Destination encode, sampled only at accept:
  - s4 → 6; else s3 → 5; else s2 → 4; else s1 → 3; else s0 → 2; else 1.
  - This mirrors the mux chain, where x6 wins on s4, and so on down to x1 when no select is set.
- Registers:
  - data_q: WIDTH bits.
  - dest_q: 3 bits, values 1..6.
  - timer_q: width clog2(TIMEOUT+1), minimum 1 bit.
  - state: EMPTY or FULL.
- Accept = din_valid & din_ready.
- EMPTY:
  - din_ready = 1; all v* = 0.
  - On accept: capture din and the encoded dest, clear the timer, go to FULL.
- FULL:
  - v[dest_q] = 1; y[dest_q] = data_q; the other outputs are 0.
  - din_ready = rdy[dest_q], combinational pass-through, so a word can be accepted every cycle.
  - rdy[dest_q] = 1 (delivery):
    - If an accept occurs in the same cycle, reload data_q/dest_q, clear the timer, and stay in FULL.
    - Otherwise go to EMPTY.
  - rdy[dest_q] = 0:
    - timer_q increments.
    - If TIMEOUT != 0 and timer_q == TIMEOUT-1: pulse drop the next cycle, go to EMPTY, and discard data_q.
    - din_ready stays 0 in that cycle.
- Ready inputs of non-selected outputs are ignored.
- Selects are ignored outside an accept cycle; changing them while FULL does not redirect the held word.
- din is ignored when din_ready = 0, whatever din_valid is.

## Timing
- Reset (asynchronous assert; release synchronous to clk):
  - state = EMPTY; data_q = 0; dest_q = 1; timer_q = 0; drop = 0.
  - All y* = 0; all v* = 0; din_ready = 1 once rst_n is high.
- Latency: a word accepted at edge N appears on y/v from edge N until the delivery edge; minimum occupancy is 1 cycle.
- Throughput: 1 word per cycle while the selected sink holds ready.
- Timeout: with continuous backpressure, a word accepted at edge N is held for TIMEOUT cycles. drop is high in the cycle after the last held cycle, and state is EMPTY in that same cycle.
- Delivery and timeout in the same cycle: delivery wins, and drop is not pulsed.
- Reset mid-operation: the held word is lost, v* clears immediately (asynchronously), and no drop pulse is generated.
- Outputs y*, v*, drop and state are registered-derived. din_ready is combinational from state and rdy*.

## Test plan
- Priority encode:
  - Stimulus: din = 0xA5 with {s4..s0} = 00000, then 00001, 00110, 01000, 11111; all rdy = 1.
  - Required: v1, v2, v4, v5, v6 in turn, each one cycle after its accept, with y = 0xA5 on that port only.
- Back-to-back:
  - Stimulus: 10 consecutive words 0x00..0x09 to dest 3 (s1 = 1) with rdy3 held at 1.
  - Required: din_ready stays 1; y3 shows 0x00..0x09 on consecutive cycles with no bubbles.
- Backpressure:
  - Stimulus: send 0x3C to dest 6; hold rdy6 = 0 for 5 cycles, then 1.
  - Required: y6 = 0x3C and v6 = 1 are held for 6 cycles; din_ready = 0 during the stall; no drop.
- Timeout (TIMEOUT = 16):
  - Stimulus: send 0x77 to dest 2; hold rdy2 = 0.
  - Required: v2 deasserts after 16 cycles; drop pulses for exactly 1 cycle; the next word is accepted afterwards.
- Select change while FULL:
  - Stimulus: accept a word to dest 4, then switch the selects to s4 = 1 and toggle rdy6.
  - Required: the word stays on y4/v4 and is delivered only when rdy4 = 1.
- Reset mid-hold:
  - Stimulus: deassert rst_n while v5 = 1.
  - Required: all v* = 0 and y* = 0 immediately; din_ready = 1 after release; drop stays 0.
